// File: rtl/hack_exec_ctrl_if.sv
// Bus bundle between the Hack execute-stage sequencer and its environment:
// instruction handshake, ALU operand/result, data memory, jump and status.
interface hack_exec_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       alu_x;
    logic [15:0]       alu_y;
    logic              alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0]       alu_out;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic              jump_valid;
    logic [15:0]       jump_target;
    logic              zr, ng;
    logic [15:0]       reg_a, reg_d;

    // master: the execute stage itself
    modport master (
        input  instr, instr_valid, alu_out, mem_rdata,
        output instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny,
               alu_f, alu_no, mem_addr, mem_rd, mem_we, mem_wdata,
               jump_valid, jump_target, zr, ng, reg_a, reg_d
    );

    // slave: the surrounding pipeline, ALU and data memory
    modport slave (
        output instr, instr_valid, alu_out, mem_rdata,
        input  instr_ready, alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny,
               alu_f, alu_no, mem_addr, mem_rd, mem_we, mem_wdata,
               jump_valid, jump_target, zr, ng, reg_a, reg_d
    );
endinterface

// File: rtl/hack_exec_ctrl.sv
// Hack execute-stage sequencer: holds A/D, fetches M, drives the ALU, writes back, jumps.
// Optional HACK_STRICT_DECODE_EN: discards C-instructions with instr[14:13] != 2'b11, flags illegal_op.
module hack_exec_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    hack_exec_ctrl_if.master   bus
`ifdef HACK_STRICT_DECODE_EN
    ,
    output logic               illegal_op
`endif
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, MREAD, EXEC, WB} state_t;

    state_t           state_q, state_d;
    logic [15:0]      a_q, a_d, d_q, d_d, m_q, m_d, res_q, res_d;
    logic [12:0]      ir_q, ir_d;   // a, c, d, j fields of the latched C-instruction
    logic             zr_q, zr_d, ng_q, ng_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             illegal_q, illegal_d;
    logic             take_jump;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            d_q       <= '0;
            m_q       <= '0;
            res_q     <= '0;
            ir_q      <= '0;
            zr_q      <= 1'b0;
            ng_q      <= 1'b0;
            lat_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            d_q       <= d_d;
            m_q       <= m_d;
            res_q     <= res_d;
            ir_q      <= ir_d;
            zr_q      <= zr_d;
            ng_q      <= ng_d;
            lat_q     <= lat_d;
            illegal_q <= illegal_d;
        end
    end

    // Flags were captured at the end of EXEC, so they are stable throughout WB
    assign take_jump = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~ng_q & ~zr_q);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        m_d       = m_q;
        res_d     = res_q;
        ir_d      = ir_q;
        zr_d      = zr_q;
        ng_d      = ng_q;
        lat_d     = lat_q;
        illegal_d = illegal_q;

        bus.instr_ready = 1'b0;
        bus.alu_x       = '0;
        bus.alu_y       = '0;
        {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = 6'b0;
        bus.mem_addr    = a_q[ADDR_W-1:0];
        bus.mem_rd      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_wdata   = '0;
        bus.jump_valid  = 1'b0;
        bus.jump_target = '0;

        unique case (state_q)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    if (!bus.instr[15]) begin
                        a_d = {1'b0, bus.instr[14:0]};
`ifdef HACK_STRICT_DECODE_EN
                    end else if (bus.instr[14:13] != 2'b11) begin
                        illegal_d = 1'b1;
`endif
                    end else begin
                        ir_d    = bus.instr[12:0];
                        lat_d   = '0;
                        state_d = bus.instr[12] ? MREAD : EXEC;
                    end
                end
            end
            MREAD: begin
                bus.mem_rd = (lat_q == '0);
                if (lat_q == LAT_LAST) begin
                    m_d     = bus.mem_rdata;
                    state_d = EXEC;
                end else begin
                    lat_d = lat_q + CNT_W'(1);
                end
            end
            EXEC: begin
                bus.alu_x = d_q;
                bus.alu_y = ir_q[12] ? m_q : a_q;
                {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = ir_q[11:6];
                res_d   = bus.alu_out;
                zr_d    = (bus.alu_out == 16'd0);
                ng_d    = bus.alu_out[15];
                state_d = WB;
            end
            WB: begin
                if (ir_q[4]) d_d = res_q;
                if (ir_q[5]) a_d = res_q;
                if (ir_q[3]) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_wdata = res_q;
                end
                if (take_jump) begin
                    bus.jump_valid  = 1'b1;
                    bus.jump_target = a_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.zr    = zr_q;
    assign bus.ng    = ng_q;
    assign bus.reg_a = a_q;
    assign bus.reg_d = d_q;

`ifdef HACK_STRICT_DECODE_EN
    assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Directed bench for hack_exec_ctrl: Hack ALU model, scoreboard of expected
// memory reads/writes and jumps, immediate-assertion checks.
module tb_hack_exec_ctrl;
    localparam int ADDR_W  = 15;
    localparam int MEM_LAT = 1;
    localparam logic [1:0] EV_RD = 2'd1, EV_WR = 2'd2, EV_JMP = 2'd3, EV_NONE = 2'd0;

    logic clk;
    logic reset;
    logic [15:0] rd_val;
    int n_assert;
    int n_fail;
    logic [33:0] exp_q[$];

    hack_exec_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef HACK_STRICT_DECODE_EN
    logic illegal_op;
`endif

    hack_exec_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef HACK_STRICT_DECODE_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Hack ALU
    always_comb begin
        logic [15:0] x1, y1, o;
        x1 = bus.alu_zx ? 16'd0 : bus.alu_x;
        x1 = bus.alu_nx ? ~x1 : x1;
        y1 = bus.alu_zy ? 16'd0 : bus.alu_y;
        y1 = bus.alu_ny ? ~y1 : y1;
        o  = bus.alu_f ? (x1 + y1) : (x1 & y1);
        bus.alu_out = bus.alu_no ? ~o : o;
    end

    assign bus.mem_rdata = rd_val;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_evt(input logic [1:0] kind, input logic [15:0] addr, input logic [15:0] data);
        logic [33:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", {32'd0, kind}, {32'd0, EV_NONE});
        end else begin
            e = exp_q.pop_front();
            check("event", {kind, addr, data}, e);
            $display("event kind=%0d addr=%0d data=%0d", kind, addr, data);
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_rd)     expect_evt(EV_RD, 16'(bus.mem_addr), 16'd0);
            if (bus.mem_we)     expect_evt(EV_WR, 16'(bus.mem_addr), bus.mem_wdata);
            if (bus.jump_valid) expect_evt(EV_JMP, bus.jump_target, 16'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, transfers one word, returns 1ns after the accept edge
    task automatic send(input logic [15:0] w);
        int n;
        n = 0;
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        while (!bus.instr_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_send", {33'd0, bus.instr_ready}, 34'd1);
        tick();
        bus.instr_valid = 1'b0;
        $display("sent instr=%h a=%0d d=%0d", w, bus.reg_a, bus.reg_d);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.instr_ready && n < 50) begin
            tick();
            n++;
        end
        check("idle_wait", {33'd0, bus.instr_ready}, 34'd1);
    endtask

    initial begin
        int cyc;
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1;
        rd_val = 16'd0;
        bus.instr = 16'd0;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {33'd0, bus.instr_ready}, 34'd1);
        check("rst_regs", {2'b0, bus.reg_a, bus.reg_d}, 34'd0);
        check("rst_outs", {28'd0, bus.mem_we, bus.mem_rd, bus.jump_valid, bus.zr, bus.ng, bus.alu_zx}, 34'd0);
`ifdef HACK_STRICT_DECODE_EN
        check("rst_illegal", {33'd0, illegal_op}, 34'd0);
`endif
        reset = 1'b0;
        tick();

        // Back-to-back A-instructions
        bus.instr = 16'h0064;
        bus.instr_valid = 1'b1;
        tick();
        check("a_instr_100", {18'd0, bus.reg_a}, 34'd100);
        check("a_ready_held", {33'd0, bus.instr_ready}, 34'd1);
        bus.instr = 16'h0007;
        tick();
        check("a_instr_7", {18'd0, bus.reg_a}, 34'd7);
        bus.instr_valid = 1'b0;

        // D=A with A=100
        send(16'h0064);
        send(16'hEC10);
        check("exec_ctrl", {28'd0, bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}, 34'b110000);
        check("exec_y", {18'd0, bus.alu_y}, 34'd100);
        check("exec_x", {18'd0, bus.alu_x}, 34'd0);
        wait_idle();
        check("d_eq_a", {18'd0, bus.reg_d}, 34'd100);
        check("flags_pos", {32'd0, bus.zr, bus.ng}, 34'd0);

        // M=D+1 at A=7
        send(16'h0007);
        exp_q.push_back({EV_WR, 16'd7, 16'd101});
        send(16'hE7C8);
        wait_idle();
        check("d_unchanged", {18'd0, bus.reg_d}, 34'd100);

        // D=D+M, measure accept-to-ready latency
        rd_val = 16'd10;
        exp_q.push_back({EV_RD, 16'd7, 16'd0});
        send(16'hF090);
        cyc = 1;
        while (!bus.instr_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check("mread_latency", 34'(cyc), 34'(MEM_LAT + 3));
        check("d_plus_m", {18'd0, bus.reg_d}, 34'd110);

        // Jumps: D=0, A=42
        send(16'hEA90);
        wait_idle();
        send(16'h002A);
        exp_q.push_back({EV_JMP, 16'd42, 16'd0});
        send(16'hE302);
        wait_idle();
        check("zr_set", {32'd0, bus.zr, bus.ng}, 34'b10);
        send(16'hE301);
        wait_idle();
        send(16'hE300);
        wait_idle();
        exp_q.push_back({EV_JMP, 16'd42, 16'd0});
        send(16'hE307);
        wait_idle();
        exp_q.push_back({EV_JMP, 16'd42, 16'd0});
        send(16'hE327);
        wait_idle();
        check("a_dest_jump", {18'd0, bus.reg_a}, 34'd0);

        // Wrap-around arithmetic
        send(16'h7FFF);
        send(16'hEC10);
        wait_idle();
        send(16'hE7D0);
        wait_idle();
        check("d_8000", {18'd0, bus.reg_d}, 34'h8000);
        check("ng_set", {32'd0, bus.zr, bus.ng}, 34'b01);
        send(16'hE090);
        wait_idle();
        check("d_ffff", {18'd0, bus.reg_d}, 34'hFFFF);
        send(16'hE7D0);
        wait_idle();
        check("wrap_zero", {1'b0, bus.zr, bus.reg_d, 16'd0}, {1'b0, 1'b1, 32'd0});

        // Reset in the middle of MREAD
        send(16'h0007);
        send(16'hEC10);
        wait_idle();
        send(16'hF090);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_ready", {33'd0, bus.instr_ready}, 34'd1);
        check("midrst_regs", {2'b0, bus.reg_a, bus.reg_d}, 34'd0);
        check("midrst_we", {32'd0, bus.mem_we, bus.mem_rd}, 34'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

`ifdef HACK_STRICT_DECODE_EN
        send(16'h0005);
        send(16'hEC10);
        wait_idle();
        send(16'h8000);
        wait_idle();
        tick();
        check("illegal_set", {33'd0, illegal_op}, 34'd1);
        check("illegal_regs", {2'b0, bus.reg_a, bus.reg_d}, {2'b0, 16'd5, 16'd5});
`endif

        repeat (3) tick();
        check("scoreboard_empty", 34'(exp_q.size()), 34'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
